i2cm_seq: RTL and testbench
===========================

# i2cm_seq

Transaction sequencer that sits between a requester (CPU register block or DMA) and the `i2cm` byte/bit engine command interface. It turns one register-style request (device address, register address, direction, length) into the full `i2cm` command sequence: START, address, register, optional repeated START, data bytes, STOP. It handles ACK/NACK and engine errors so the requester never issues per-byte commands.

## Interface
- `LW`, default 4: length field width; a transfer carries 1..2^LW data bytes.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: sequencer idle, request accepted when both high.
- `req_dev` in 7: 7-bit device address.
- `req_reg` in 8: register address byte.
- `req_rnw` in 1: 1 = read, 0 = write.
- `req_len` in LW: data byte count minus one.
- `wr_data` in 8: write data byte.
- `wr_valid` in 1: write byte present.
- `wr_ready` out 1: write byte consumed when both high.
- `rd_data` out 8: read byte.
- `rd_valid` out 1: one-cycle strobe, no backpressure.
- `done` out 1: one-cycle strobe at transaction end.
- `nack` out 1: status, valid with `done`; slave NACKed an address/reg/write byte.
- `abort` out 1: status, valid with `done`; engine reported `error`.
- `busy` out 1: high from acceptance through `done`.
- `cmds` out 5: one-hot command to engine (CMD_START/WRITE/READ/STOP from `i2cm.vh`).
- `cdone` in 5: engine one-cycle completion, same encoding.
- `tbyte` out 8: byte for WRITE.
- `rbyte` in 8: byte from READ, valid in the `cdone` cycle.
- `rxack` in 1: ACK bit sampled after WRITE (0 = ACK), valid in the `cdone` cycle.
- `txack` out 1: ACK bit driven after READ.
- `error` in 1: engine bus error / arbitration loss.

## Operation
- States: IDLE, START, DEVW, REG, WDATA, RSTART, DEVR, RDATA, STOP, FIN.
- All outputs are registered. Reset values: `cmds`=0, `tbyte`=0, `txack`=0, `rd_data`=0, all strobes and flags 0, `req_ready`=1, state IDLE, byte counter 0.
- IDLE: on `req_valid & req_ready`, latch dev/reg/rnw/len. Then `cmds`=START -> START.
- START done -> `tbyte`={dev,0}, `cmds`=WRITE -> DEVW.
- DEVW done: if ACK -> `tbyte`=reg, WRITE -> REG.
- REG done, ACK: if rnw -> `cmds`=START (repeated start) -> RSTART; else -> WDATA.
- WDATA, fetch phase (`cmds`=0): `wr_ready`=1. On handshake, `tbyte`=wr_data, `cmds`=WRITE. On done with ACK: if counter==len -> STOP; else counter+1 and fetch again.
- An empty write stream stalls with `cmds`=0; the bus is held and there is no timeout.
- RSTART done -> `tbyte`={dev,1}, WRITE -> DEVR.
- DEVR done with ACK -> `cmds`=READ, `txack`=(len==0) -> RDATA.
- RDATA done: `rd_data`=rbyte, `rd_valid`=1. If counter==len -> STOP; else counter+1, `txack`=(counter+1==len), reissue READ.
- NACK (`rxack`=1) on any WRITE done: set `nack` -> STOP; remaining write bytes are not fetched.
- STOP done -> FIN. FIN: `done`=1 for one cycle, `busy`=0 -> IDLE.
- `error` high in any non-IDLE state takes priority over `cdone`: `cmds`=0 at once, set `abort`, no STOP -> FIN.
- `nack` and `abort` hold until the next request is accepted.
- Counter is LW bits and never wraps; the len==2^LW-1 compare ends the transfer before overflow.

## Timing
- A command bit goes active the cycle after acceptance or `cdone`. It is cleared/replaced on the same edge that samples `cdone`, so the engine sees the next command in its IDLE cycle.
- `cmds` never has more than one bit set.
- `tbyte` and `txack` are stable while the corresponding command is active.
- `rd_valid` fires the cycle after the READ `cdone`.
- `done` fires the cycle after the STOP `cdone`, or the cycle after `error`.
- `req_ready` is low from the acceptance edge until the `done` cycle.
- Async reset mid-transaction drops `cmds` at once; no STOP is generated.

## Test plan
- Write dev=0x50, reg=0x10, len=1, bytes 0xA5,0x3C, all ACK -> engine sees START, WRITE 0xA0, WRITE 0x10, WRITE 0xA5, WRITE 0x3C, STOP; `done` with nack=0.
- Read dev=0x50, reg=0x02, len=2, slave returns 0x11,0x22,0x33 -> START, W 0xA0, W 0x02, START, W 0xA1, READ×3 with txack 0,0,1; three `rd_valid`; STOP; `done`.
- DEVW NACK -> STOP follows immediately; `nack`=1; `wr_ready` never asserted.
- Write with `wr_valid` low for 20 cycles before byte 2 -> `cmds`=0 during the stall; sequence resumes; correct bytes.
- `error` pulsed during RDATA -> `cmds`=0 next cycle; `done`=1, abort=1, no STOP.
- Async reset during DEVW, then new request -> outputs at reset values; next request runs cleanly.

Source files
------------

// File: rtl/i2cm_seq.sv
// i2cm_seq: expands one register-style read/write request into the i2cm engine
// command stream (START, address, register, repeated START, data, STOP).
module i2cm_seq #(
    parameter int unsigned LW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [6:0]    req_dev,
    input  logic [7:0]    req_reg,
    input  logic          req_rnw,
    input  logic [LW-1:0] req_len,
    input  logic [7:0]    wr_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic          done,
    output logic          nack,
    output logic          abort,
    output logic          busy,
    output logic [4:0]    cmds,
    input  logic [4:0]    cdone,
    output logic [7:0]    tbyte,
    input  logic [7:0]    rbyte,
    input  logic          rxack,
    output logic          txack,
    input  logic          error
);

    localparam logic [4:0] CMD_START = 5'b00001;
    localparam logic [4:0] CMD_WRITE = 5'b00010;
    localparam logic [4:0] CMD_READ  = 5'b00100;
    localparam logic [4:0] CMD_STOP  = 5'b01000;

    typedef enum logic [3:0] {
        StIdle, StStart, StDevw, StReg, StWdata, StRstart, StDevr, StRdata, StStop, StFin
    } state_e;

    state_e        state_q, state_d;
    logic [4:0]    cmds_q, cmds_d;
    logic [7:0]    tbyte_q, tbyte_d;
    logic          txack_q, txack_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          done_q, done_d;
    logic          nack_q, nack_d;
    logic          abort_q, abort_d;
    logic          busy_q, busy_d;
    logic          req_ready_q, req_ready_d;
    logic          wr_ready_q, wr_ready_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [6:0]    dev_q;
    logic [7:0]    regad_q;
    logic          rnw_q;
    logic [LW-1:0] len_q;

    logic          accept;
    logic          cmd_done;
    logic          last;
    logic          wr_hs;
    logic          abort_now;
    logic [LW-1:0] cnt_inc;

    assign accept    = req_valid & req_ready_q;
    // The state implies which command is outstanding, so one completion flag suffices.
    assign cmd_done  = |(cdone & cmds_q);
    assign last      = (cnt_q == len_q);
    assign wr_hs     = wr_valid & wr_ready_q;
    assign cnt_inc   = cnt_q + LW'(1);
    assign abort_now = error & (state_q != StIdle) & (state_q != StFin);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort_now) begin
            state_d = StFin;
        end else begin
            unique case (state_q)
                StIdle:   if (accept) state_d = StStart;
                StStart:  if (cmd_done) state_d = StDevw;
                StDevw:   if (cmd_done) state_d = rxack ? StStop : StReg;
                StReg:    if (cmd_done) state_d = rxack ? StStop : (rnw_q ? StRstart : StWdata);
                StWdata:  if (cmd_done && (rxack || last)) state_d = StStop;
                StRstart: if (cmd_done) state_d = StDevr;
                StDevr:   if (cmd_done) state_d = rxack ? StStop : StRdata;
                StRdata:  if (cmd_done && last) state_d = StStop;
                StStop:   if (cmd_done) state_d = StFin;
                StFin:    state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        cmds_d      = cmds_q;
        tbyte_d     = tbyte_q;
        txack_d     = txack_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        done_d      = 1'b0;
        nack_d      = nack_q;
        abort_d     = abort_q;
        busy_d      = busy_q;
        req_ready_d = req_ready_q;
        wr_ready_d  = wr_ready_q;
        cnt_d       = cnt_q;
        if (abort_now) begin
            // Bus state is unknown after an engine error, so no STOP is attempted.
            cmds_d     = '0;
            abort_d    = 1'b1;
            wr_ready_d = 1'b0;
            done_d     = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        cmds_d      = CMD_START;
                        nack_d      = 1'b0;
                        abort_d     = 1'b0;
                        busy_d      = 1'b1;
                        req_ready_d = 1'b0;
                        cnt_d       = '0;
                    end
                end
                StStart, StRstart: begin
                    if (cmd_done) begin
                        tbyte_d = {dev_q, (state_q == StRstart)};
                        cmds_d  = CMD_WRITE;
                    end
                end
                StDevw, StReg, StDevr: begin
                    if (cmd_done) begin
                        if (rxack) begin
                            nack_d = 1'b1;
                            cmds_d = CMD_STOP;
                        end else if (state_q == StDevw) begin
                            tbyte_d = regad_q;
                            cmds_d  = CMD_WRITE;
                        end else if (state_q == StDevr) begin
                            cmds_d  = CMD_READ;
                            txack_d = (len_q == '0);
                        end else if (rnw_q) begin
                            cmds_d = CMD_START;
                        end else begin
                            cmds_d     = '0;
                            wr_ready_d = 1'b1;
                        end
                    end
                end
                StWdata: begin
                    if (wr_hs) begin
                        tbyte_d    = wr_data;
                        cmds_d     = CMD_WRITE;
                        wr_ready_d = 1'b0;
                    end else if (cmd_done) begin
                        if (rxack) begin
                            nack_d = 1'b1;
                            cmds_d = CMD_STOP;
                        end else if (last) begin
                            cmds_d = CMD_STOP;
                        end else begin
                            cnt_d      = cnt_inc;
                            cmds_d     = '0;
                            wr_ready_d = 1'b1;
                        end
                    end
                end
                StRdata: begin
                    if (cmd_done) begin
                        rd_data_d  = rbyte;
                        rd_valid_d = 1'b1;
                        if (last) begin
                            cmds_d = CMD_STOP;
                        end else begin
                            cnt_d   = cnt_inc;
                            txack_d = (cnt_inc == len_q);
                        end
                    end
                end
                StStop: begin
                    if (cmd_done) begin
                        cmds_d = '0;
                        done_d = 1'b1;
                    end
                end
                StFin: begin
                    busy_d      = 1'b0;
                    req_ready_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmds_q      <= '0;
            tbyte_q     <= '0;
            txack_q     <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            nack_q      <= 1'b0;
            abort_q     <= 1'b0;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
            wr_ready_q  <= 1'b0;
            cnt_q       <= '0;
            dev_q       <= '0;
            regad_q     <= '0;
            rnw_q       <= 1'b0;
            len_q       <= '0;
        end else begin
            cmds_q      <= cmds_d;
            tbyte_q     <= tbyte_d;
            txack_q     <= txack_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            done_q      <= done_d;
            nack_q      <= nack_d;
            abort_q     <= abort_d;
            busy_q      <= busy_d;
            req_ready_q <= req_ready_d;
            wr_ready_q  <= wr_ready_d;
            cnt_q       <= cnt_d;
            if (accept) begin
                dev_q   <= req_dev;
                regad_q <= req_reg;
                rnw_q   <= req_rnw;
                len_q   <= req_len;
            end
        end
    end

    assign cmds      = cmds_q;
    assign tbyte     = tbyte_q;
    assign txack     = txack_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign done      = done_q;
    assign nack      = nack_q;
    assign abort     = abort_q;
    assign busy      = busy_q;
    assign req_ready = req_ready_q;
    assign wr_ready  = wr_ready_q;

endmodule

// File: tb/tb_i2cm_seq.sv
// Testbench for i2cm_seq: behavioural i2cm engine plus scoreboards for the
// command stream and the requester-side read/done outputs.
module tb_i2cm_seq;

    localparam int LW  = 4;
    localparam int LAT = 2;
    localparam logic [4:0] M_START = 5'b00001;
    localparam logic [4:0] M_WRITE = 5'b00010;
    localparam logic [4:0] M_READ  = 5'b00100;
    localparam logic [4:0] M_STOP  = 5'b01000;

    typedef struct packed {
        logic [4:0] cmd;
        logic [7:0] data;
        logic       txack;
    } cmd_t;

    typedef struct packed {
        logic       is_done;
        logic [7:0] data;
        logic       nack;
        logic       abort;
    } out_t;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [6:0]    req_dev;
    logic [7:0]    req_reg;
    logic          req_rnw;
    logic [LW-1:0] req_len;
    logic [7:0]    wr_data;
    logic          wr_valid;
    logic          wr_ready;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          done;
    logic          nack;
    logic          abort;
    logic          busy;
    logic [4:0]    cmds;
    logic [4:0]    cdone;
    logic [7:0]    tbyte;
    logic [7:0]    rbyte;
    logic          rxack;
    logic          txack;
    logic          error;

    i2cm_seq #(.LW(LW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_dev   (req_dev),
        .req_reg   (req_reg),
        .req_rnw   (req_rnw),
        .req_len   (req_len),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .done      (done),
        .nack      (nack),
        .abort     (abort),
        .busy      (busy),
        .cmds      (cmds),
        .cdone     (cdone),
        .tbyte     (tbyte),
        .rbyte     (rbyte),
        .rxack     (rxack),
        .txack     (txack),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    cmd_t       exp_cmd_q[$];
    out_t       exp_out_q[$];
    logic       rxack_q[$];
    logic [7:0] rbyte_q[$];
    logic [7:0] wr_q[$];

    int         wr_idx = 0;
    int         stall_idx = -1;
    int         stall_left = 0;
    logic       wr_pop = 1'b0;
    logic       seen_wr_ready = 1'b0;

    logic       eng_active = 1'b0;
    int         eng_cnt = 0;
    logic [4:0] eng_cmd = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic exp_cmd(input logic [4:0] c, input logic [7:0] d, input logic t);
        cmd_t e;
        e.cmd = c;
        e.data = d;
        e.txack = t;
        exp_cmd_q.push_back(e);
    endtask

    task automatic exp_out(input logic is_done, input logic [7:0] d, input logic n,
                           input logic a);
        out_t e;
        e.is_done = is_done;
        e.data = d;
        e.nack = n;
        e.abort = a;
        exp_out_q.push_back(e);
    endtask

    // Engine model: picks up each command, completes it LAT cycles later, and checks it.
    always @(negedge clk) begin
        cdone = '0;
        if (!$onehot0(cmds)) begin
            errors++;
            $display("FAIL cmds_onehot: got %b, required at most one bit set", cmds);
        end
        if (!rst_n || error || cmds == '0) begin
            eng_active = 1'b0;
        end else if (!eng_active) begin
            cmd_t e;
            eng_active = 1'b1;
            eng_cnt = LAT;
            eng_cmd = cmds;
            checks++;
            if (exp_cmd_q.size() == 0) begin
                errors++;
                $display("FAIL cmd_unexpected: got cmds=%b tbyte=0x%h, required no command",
                         cmds, tbyte);
            end else begin
                e = exp_cmd_q.pop_front();
                if (cmds !== e.cmd || (e.cmd == M_WRITE && tbyte !== e.data) ||
                    (e.cmd == M_READ && txack !== e.txack)) begin
                    errors++;
                    $display("FAIL cmd: got cmds=%b tbyte=0x%h txack=%b, required cmds=%b tbyte=0x%h txack=%b",
                             cmds, tbyte, txack, e.cmd, e.data, e.txack);
                end
            end
        end else begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                cdone = eng_cmd;
                eng_active = 1'b0;
                if (eng_cmd == M_WRITE) rxack = (rxack_q.size() != 0) ? rxack_q.pop_front() : 1'b0;
                if (eng_cmd == M_READ) rbyte = (rbyte_q.size() != 0) ? rbyte_q.pop_front() : 8'h00;
            end
        end
    end

    // Requester-side monitor.
    always @(negedge clk) begin
        if (rst_n && (rd_valid || done)) begin
            out_t e;
            checks++;
            if (exp_out_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got rd_valid=%b done=%b, required nothing",
                         rd_valid, done);
            end else begin
                e = exp_out_q.pop_front();
                if (rd_valid && (e.is_done || rd_data !== e.data)) begin
                    errors++;
                    $display("FAIL rd_data: got rd 0x%h, required done=%b data 0x%h",
                             rd_data, e.is_done, e.data);
                end else if (done && (!e.is_done || nack !== e.nack || abort !== e.abort)) begin
                    errors++;
                    $display("FAIL done_status: got nack=%b abort=%b, required done=%b nack=%b abort=%b",
                             nack, abort, e.is_done, e.nack, e.abort);
                end
            end
        end
        if (wr_ready) seen_wr_ready = 1'b1;
    end

    // Write-data source with an optional stall before byte stall_idx.
    always @(negedge clk) begin
        if (wr_pop) begin
            void'(wr_q.pop_front());
            wr_idx++;
            wr_pop = 1'b0;
        end
        if (wr_q.size() != 0 && wr_idx == stall_idx && stall_left > 0) begin
            wr_valid = 1'b0;
            if (wr_ready) begin
                stall_left--;
                checks++;
                if (cmds !== 5'b0) begin
                    errors++;
                    $display("FAIL stall_cmds: got %b, required 00000", cmds);
                end
            end
        end else if (wr_q.size() != 0) begin
            wr_valid = 1'b1;
            wr_data = wr_q[0];
            if (wr_ready) wr_pop = 1'b1;
        end else begin
            wr_valid = 1'b0;
        end
    end

    task automatic run_req(input logic [6:0] dev, input logic [7:0] rg, input logic rnw,
                           input logic [LW-1:0] len);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b1;
        req_dev = dev;
        req_reg = rg;
        req_rnw = rnw;
        req_len = len;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done, required done within 3000 cycles", name);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_drained(input string name);
        chk({name, "_cmd_left"}, exp_cmd_q.size(), 0);
        chk({name, "_out_left"}, exp_out_q.size(), 0);
        exp_cmd_q.delete();
        exp_out_q.delete();
        rxack_q.delete();
        rbyte_q.delete();
        wr_q.delete();
        wr_idx = 0;
        stall_idx = -1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish within 500us");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_dev = '0;
        req_reg = '0;
        req_rnw = 1'b0;
        req_len = '0;
        wr_valid = 1'b0;
        wr_data = '0;
        cdone = '0;
        rbyte = '0;
        rxack = 1'b0;
        error = 1'b0;
        #22;
        chk("rst_cmds", cmds, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_flags", {busy, done, nack, abort, rd_valid, wr_ready, txack}, 0);
        chk("rst_bytes", {tbyte, rd_data}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Plain write, all ACK.
        wr_q = '{8'hA5, 8'h3C};
        exp_cmd(M_START, 8'h00, 0);
        exp_cmd(M_WRITE, 8'hA0, 0);
        exp_cmd(M_WRITE, 8'h10, 0);
        exp_cmd(M_WRITE, 8'hA5, 0);
        exp_cmd(M_WRITE, 8'h3C, 0);
        exp_cmd(M_STOP, 8'h00, 0);
        exp_out(1, 8'h00, 0, 0);
        run_req(7'h50, 8'h10, 1'b0, 4'd1);
        chk("busy_after_accept", busy, 1);
        chk("req_ready_after_accept", req_ready, 0);
        wait_done("write");
        chk("idle_after_write", {busy, req_ready}, 2'b01);
        chk_drained("write");

        // Read three bytes with repeated START.
        rbyte_q = '{8'h11, 8'h22, 8'h33};
        exp_cmd(M_START, 8'h00, 0);
        exp_cmd(M_WRITE, 8'hA0, 0);
        exp_cmd(M_WRITE, 8'h02, 0);
        exp_cmd(M_START, 8'h00, 0);
        exp_cmd(M_WRITE, 8'hA1, 0);
        exp_cmd(M_READ, 8'h00, 0);
        exp_cmd(M_READ, 8'h00, 0);
        exp_cmd(M_READ, 8'h00, 1);
        exp_cmd(M_STOP, 8'h00, 0);
        exp_out(0, 8'h11, 0, 0);
        exp_out(0, 8'h22, 0, 0);
        exp_out(0, 8'h33, 0, 0);
        exp_out(1, 8'h00, 0, 0);
        run_req(7'h50, 8'h02, 1'b1, 4'd2);
        wait_done("read");
        chk_drained("read");

        // Device address NACK.
        seen_wr_ready = 1'b0;
        rxack_q = '{1'b1};
        exp_cmd(M_START, 8'h00, 0);
        exp_cmd(M_WRITE, 8'hA0, 0);
        exp_cmd(M_STOP, 8'h00, 0);
        exp_out(1, 8'h00, 1, 0);
        run_req(7'h50, 8'h20, 1'b0, 4'd0);
        wait_done("nack");
        chk("nack_no_wr_ready", seen_wr_ready, 0);
        chk("nack_held", nack, 1);
        chk_drained("nack");

        // Write with a 20-cycle source stall before the second byte.
        wr_q = '{8'h01, 8'h02, 8'h03};
        stall_idx = 1;
        stall_left = 20;
        exp_cmd(M_START, 8'h00, 0);
        exp_cmd(M_WRITE, 8'h74, 0);
        exp_cmd(M_WRITE, 8'h07, 0);
        exp_cmd(M_WRITE, 8'h01, 0);
        exp_cmd(M_WRITE, 8'h02, 0);
        exp_cmd(M_WRITE, 8'h03, 0);
        exp_cmd(M_STOP, 8'h00, 0);
        exp_out(1, 8'h00, 0, 0);
        run_req(7'h3A, 8'h07, 1'b0, 4'd2);
        wait_done("stall");
        chk("stall_consumed", stall_left, 0);
        chk_drained("stall");

        // Engine error during RDATA.
        rbyte_q = '{8'h44, 8'h55, 8'h66};
        exp_cmd(M_START, 8'h00, 0);
        exp_cmd(M_WRITE, 8'hA0, 0);
        exp_cmd(M_WRITE, 8'h02, 0);
        exp_cmd(M_START, 8'h00, 0);
        exp_cmd(M_WRITE, 8'hA1, 0);
        exp_cmd(M_READ, 8'h00, 0);
        exp_cmd(M_READ, 8'h00, 0);
        exp_out(0, 8'h44, 0, 0);
        exp_out(1, 8'h00, 0, 1);
        run_req(7'h50, 8'h02, 1'b1, 4'd2);
        begin
            int n = 0;
            while (!rd_valid && n < 500) begin
                @(negedge clk);
                n++;
            end
        end
        #2 error = 1'b1;
        @(posedge clk);
        #1 error = 1'b0;
        @(negedge clk);
        chk("abort_cmds_zero", cmds, 0);
        chk("abort_done", done, 1);
        repeat (20) @(negedge clk);
        chk("abort_held", abort, 1);
        chk_drained("abort");

        // Async reset while the device-address WRITE is outstanding.
        exp_cmd(M_START, 8'h00, 0);
        exp_cmd(M_WRITE, 8'hA0, 0);
        run_req(7'h50, 8'h10, 1'b1, 4'd0);
        begin
            int n = 0;
            while (cmds !== M_WRITE && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cmds", cmds, 0);
        chk("arst_ready_busy", {req_ready, busy}, 2'b10);
        chk("arst_flags", {nack, abort, done, tbyte, txack}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_drained("arst");

        // Single-byte read after reset (txack on the only byte).
        rbyte_q = '{8'h9C};
        exp_cmd(M_START, 8'h00, 0);
        exp_cmd(M_WRITE, 8'h42, 0);
        exp_cmd(M_WRITE, 8'hFF, 0);
        exp_cmd(M_START, 8'h00, 0);
        exp_cmd(M_WRITE, 8'h43, 0);
        exp_cmd(M_READ, 8'h00, 1);
        exp_cmd(M_STOP, 8'h00, 0);
        exp_out(0, 8'h9C, 0, 0);
        exp_out(1, 8'h00, 0, 0);
        run_req(7'h21, 8'hFF, 1'b1, 4'd0);
        wait_done("read1");
        chk_drained("read1");

        // Maximum length read: 16 bytes, counter must not wrap.
        exp_cmd(M_START, 8'h00, 0);
        exp_cmd(M_WRITE, 8'hFE, 0);
        exp_cmd(M_WRITE, 8'h80, 0);
        exp_cmd(M_START, 8'h00, 0);
        exp_cmd(M_WRITE, 8'hFF, 0);
        for (int i = 0; i < 16; i++) begin
            logic [7:0] b;
            b = 8'(i * 7 + 3);
            rbyte_q.push_back(b);
            exp_cmd(M_READ, 8'h00, (i == 15));
            exp_out(0, b, 0, 0);
        end
        exp_cmd(M_STOP, 8'h00, 0);
        exp_out(1, 8'h00, 0, 0);
        run_req(7'h7F, 8'h80, 1'b1, 4'd15);
        wait_done("readmax");
        chk_drained("readmax");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
